interpolation_ctrl: RTL

INTERPOLATION_CTRL -- requirements
Module: interpolation_ctrl

---
 rtl/interpolation_ctrl_pkg.sv | 60 ++++++
 rtl/interp_step_rom.sv | 14 +
 rtl/interpolation_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/interpolation_ctrl_pkg.sv
// Shared channel-estimation definitions: controller state encoding, sizing
// constants, and the per-step mux/enable table for the pilot interpolator.
package interpolation_ctrl_pkg;

    // Default schedule length and pilot-shift select width
    localparam int N_STEPS_DEF = 6;
    localparam int SHIFT_W_DEF = 2;

    // Widths of the step index and the datapath mux selects
    localparam int IDX_W    = 3;
    localparam int OPSEL_W  = 3;
    localparam int OUTSEL_W = 2;

    // Controller states; the fourth code is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // One row of the interpolation schedule
    typedef struct packed {
        logic [OPSEL_W-1:0]  s1a;
        logic [OPSEL_W-1:0]  s1b;
        logic [OPSEL_W-1:0]  s2a;
        logic [OPSEL_W-1:0]  s2b;
        logic [OUTSEL_W-1:0] s_h1;
        logic [OUTSEL_W-1:0] s_h2;
        logic                en_e;
        logic                en_2e;
        logic                en_5e;
    } step_ctrl_t;

    localparam int STEP_CTRL_W = $bits(step_ctrl_t);

    // Schedule rows: s1a, s1b, s2a, s2b, s_h1, s_h2, en_E, en_2E, en_5E
    localparam step_ctrl_t STEP_0    = '{3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0};
    localparam step_ctrl_t STEP_1    = '{3'd1, 3'd1, 3'd1, 3'd1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1};
    localparam step_ctrl_t STEP_2    = '{3'd2, 3'd2, 3'd2, 3'd2, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
    localparam step_ctrl_t STEP_3    = '{3'd3, 3'd3, 3'd3, 3'd3, 2'd3, 2'd2, 1'b0, 1'b1, 1'b0};
    localparam step_ctrl_t STEP_4    = '{3'd4, 3'd4, 3'd4, 3'd0, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1};
    localparam step_ctrl_t STEP_5    = '{3'd0, 3'd0, 3'd0, 3'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    localparam step_ctrl_t STEP_NONE = '{3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};

    // Step index to schedule row; indices past the table give an all-zero row
    function automatic step_ctrl_t step_lookup(input logic [IDX_W-1:0] idx);
        step_ctrl_t row;
        case (idx)
            3'd0:    row = STEP_0;
            3'd1:    row = STEP_1;
            3'd2:    row = STEP_2;
            3'd3:    row = STEP_3;
            3'd4:    row = STEP_4;
            3'd5:    row = STEP_5;
            default: row = STEP_NONE;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/interp_step_rom.sv
// Combinational schedule ROM: step index in, packed select/enable row out.
module interp_step_rom
    import interpolation_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0]       step_i,
    output logic [STEP_CTRL_W-1:0] ctrl_o
);

    // Pure table decode, no state
    always_comb begin
        ctrl_o = step_lookup(step_i);
    end

endmodule

// File: rtl/interpolation_ctrl.sv
// Pilot interpolation controller. Walks the step schedule once per accepted
// start, holding the schedule while the downstream equalizer stalls, and
// pulses the partial-sum register enables only on cycles the step advances.
module interpolation_ctrl
    import interpolation_ctrl_pkg::*;
#(
    parameter int N_STEPS = N_STEPS_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] nrs_shift,
    input  logic               out_ready,
    output logic [2:0]         s1a,
    output logic [2:0]         s1b,
    output logic [2:0]         s2a,
    output logic [2:0]         s2b,
    output logic [1:0]         s_h1,
    output logic [1:0]         s_h2,
    output logic               en_reg_E,
    output logic               en_reg_2E,
    output logic               en_reg_5E,
    output logic [SHIFT_W-1:0] sel_est,
    output logic               h_valid,
    output logic [2:0]         h_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(N_STEPS - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   cnt_d;
    logic [SHIFT_W-1:0] sel_est_q;

    logic                   run_ok;
    logic                   advance;
    logic [STEP_CTRL_W-1:0] rom_vec;
    step_ctrl_t             rom_ctrl;

    // A RUN state with an out-of-range count is treated as illegal
    assign run_ok  = (state_q == ST_RUN) && (cnt_q <= LAST_STEP);
    assign advance = run_ok && out_ready;
    assign cnt_d   = cnt_q + IDX_W'(1);

    // Controller FSM: schedule walk, stall hold and illegal-state recovery
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_est_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q   <= ST_RUN;
                        sel_est_q <= nrs_shift;
                    end
                end
                ST_RUN: begin
                    if (!run_ok) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (out_ready) begin
                        if (cnt_q == LAST_STEP) begin
                            state_q <= ST_DONE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    interp_step_rom u_step_rom (
        .step_i (cnt_q),
        .ctrl_o (rom_vec)
    );

    // Selects follow the registered step; enables additionally need a transfer
    always_comb begin
        rom_ctrl  = step_ctrl_t'(rom_vec);
        s1a       = '0;
        s1b       = '0;
        s2a       = '0;
        s2b       = '0;
        s_h1      = '0;
        s_h2      = '0;
        en_reg_E  = 1'b0;
        en_reg_2E = 1'b0;
        en_reg_5E = 1'b0;
        h_idx     = '0;
        if (run_ok) begin
            s1a   = rom_ctrl.s1a;
            s1b   = rom_ctrl.s1b;
            s2a   = rom_ctrl.s2a;
            s2b   = rom_ctrl.s2b;
            s_h1  = rom_ctrl.s_h1;
            s_h2  = rom_ctrl.s_h2;
            h_idx = cnt_q;
        end
        if (advance) begin
            en_reg_E  = rom_ctrl.en_e;
            en_reg_2E = rom_ctrl.en_2e;
            en_reg_5E = rom_ctrl.en_5e;
        end
    end

    assign h_valid = run_ok;
    assign busy    = run_ok || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign sel_est = sel_est_q;

endmodule
